// File: rtl/div_radix2_pkg.sv
// Shared state encoding for the sequential radix-2 divider.
package div_radix2_pkg;

  localparam int DIV_STATE_WIDTH = 2;

  typedef enum logic [DIV_STATE_WIDTH-1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, select.
module div_radix2_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] trial_s;

  // Shifted remainder keeps its MSB so the subtraction cannot overflow.
  always_comb begin
    rem_sh_s = {rem_i, quo_i[XLEN-1]};
    trial_s  = rem_sh_s - {1'b0, div_i};
    if (trial_s[XLEN] == 1'b0) begin
      rem_o = trial_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_radix2_seq.sv
// Multi-cycle unsigned restoring divider; returns quotient or remainder with a one-cycle ready pulse.
module div_radix2_seq
  import div_radix2_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            is_q_i,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  div_state_t      state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, div_r;
  logic [XLEN-1:0] rem_nx_s, quo_nx_s;
  logic            sel_q_r;
  logic            ready_r;
  logic [XLEN-1:0] result_r;
  logic            load_s, step_s, finish_s, div_zero_s;

  div_radix2_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_r),
    .quo_i (quo_r),
    .div_i (div_r),
    .rem_o (rem_nx_s),
    .quo_o (quo_nx_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a dropped request while BUSY aborts the operation.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (req_i) begin
          state_nx_s = (b_i == {XLEN{1'b0}}) ? DIV_DONE : DIV_BUSY;
        end else begin
          state_nx_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (!req_i) begin
          state_nx_s = DIV_IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          state_nx_s = DIV_DONE;
        end else begin
          state_nx_s = DIV_BUSY;
        end
      end
      DIV_DONE: state_nx_s = DIV_IDLE;
      default:  state_nx_s = DIV_IDLE;
    endcase
  end

  // Datapath control decode.
  always_comb begin
    load_s     = (state_r == DIV_IDLE) && req_i;
    step_s     = (state_r == DIV_BUSY) && req_i;
    finish_s   = (state_nx_s == DIV_DONE);
    div_zero_s = (b_i == {XLEN{1'b0}});
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r   <= {CNT_W{1'b0}};
      rem_r   <= {XLEN{1'b0}};
      quo_r   <= {XLEN{1'b0}};
      div_r   <= {XLEN{1'b0}};
      sel_q_r <= 1'b0;
    end else if (load_s) begin
      cnt_r   <= CNT_W'(XLEN);
      rem_r   <= {XLEN{1'b0}};
      quo_r   <= a_i;
      div_r   <= b_i;
      sel_q_r <= is_q_i;
    end else if (step_s) begin
      cnt_r   <= cnt_r - CNT_W'(1);
      rem_r   <= rem_nx_s;
      quo_r   <= quo_nx_s;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Result and ready registered on entry to DONE; divide-by-zero resolves straight from IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_r  <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      ready_r <= finish_s;
      if (finish_s && (state_r == DIV_IDLE)) begin
        result_r <= (is_q_i && div_zero_s) ? {XLEN{1'b1}} : a_i;
      end else if (finish_s) begin
        result_r <= sel_q_r ? quo_nx_s : rem_nx_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign ready_o  = ready_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_div_radix2_seq.sv
// Directed-vector bench for div_radix2_seq with hand-computed expectations.
module tb_div_radix2_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        is_q_i;
  logic        ready_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  div_radix2_seq #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .is_q_i   (is_q_i),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  // Presents one request at a negedge (cycle 0) and waits for the ready pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic q,
                        output int lat, output logic [31:0] res);
    @(negedge clk_i);
    a_i = a; b_i = b; is_q_i = q; req_i = 1'b1;
    lat = 0; res = 32'h0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin
        lat = i + 1;
        res = result_o;
        break;
      end
    end
    req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = 1'b0; a_i = 32'h0; b_i = 32'h0; is_q_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] res;
    run_op(32'd100, 32'd7, 1'b1, lat, res);
    total++; if (lat !== 33) begin bad++; $display("FAIL q100_7_lat got=%0d exp=33", lat); end
    total++; if (res !== 32'd14) begin bad++; $display("FAIL q100_7 got=%0d exp=14", res); end
    @(posedge clk_i); #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b exp=0", ready_o); end
    run_op(32'd100, 32'd7, 1'b0, lat, res);
    total++; if (res !== 32'd2) begin bad++; $display("FAIL r100_7 got=%0d exp=2", res); end
  endtask

  task automatic test_width_edges();
    int lat; logic [31:0] res;
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, lat, res);
    total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL qmax_1 got=%h exp=ffffffff", res); end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, res);
    total++; if (res !== 32'h0) begin bad++; $display("FAIL rmax_1 got=%h exp=0", res); end
    run_op(32'd5, 32'hFFFF_FFFF, 1'b1, lat, res);
    total++; if (res !== 32'h0) begin bad++; $display("FAIL q5_max got=%h exp=0", res); end
    run_op(32'd5, 32'hFFFF_FFFF, 1'b0, lat, res);
    total++; if (res !== 32'd5) begin bad++; $display("FAIL r5_max got=%h exp=5", res); end
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, lat, res);
    total++; if (res !== 32'h7FFF_FFFF) begin bad++; $display("FAIL rmax_msb got=%h exp=7fffffff", res); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] res;
    run_op(32'd5, 32'd0, 1'b1, lat, res);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_lat got=%0d exp=1", lat); end
    total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_q got=%h exp=ffffffff", res); end
    run_op(32'd5, 32'd0, 1'b0, lat, res);
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_lat_r got=%0d exp=1", lat); end
    total++; if (res !== 32'd5) begin bad++; $display("FAIL dz_r got=%h exp=5", res); end
  endtask

  task automatic test_operand_hold();
    int lat;
    @(negedge clk_i);
    a_i = 32'd100; b_i = 32'd7; is_q_i = 1'b1; req_i = 1'b1;
    @(negedge clk_i);
    a_i = 32'd81; b_i = 32'd9; is_q_i = 1'b0;
    lat = 1;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin lat = i + 1; break; end
    end
    total++; if (result_o !== 32'd14) begin bad++; $display("FAIL sample_once got=%0d exp=14", result_o); end
    total++; if (lat !== 33) begin bad++; $display("FAIL sample_once_lat got=%0d exp=33", lat); end
    req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int cyc1 = 0, cyc2 = 0;
    logic [31:0] r1 = 32'h0, r2 = 32'h0;
    @(negedge clk_i);
    a_i = 32'd100; b_i = 32'd7; is_q_i = 1'b1; req_i = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk_i); #1;
      if (ready_o) begin
        pulses++;
        if (pulses == 1) begin
          cyc1 = c; r1 = result_o;
          a_i = 32'd81; b_i = 32'd9;
        end else if (pulses == 2) begin
          cyc2 = c; r2 = result_o;
          req_i = 1'b0;
        end
      end
    end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    total++; if (cyc1 !== 33) begin bad++; $display("FAIL b2b_cyc1 got=%0d exp=33", cyc1); end
    total++; if (cyc2 !== 67) begin bad++; $display("FAIL b2b_cyc2 got=%0d exp=67", cyc2); end
    total++; if (r1 !== 32'd14) begin bad++; $display("FAIL b2b_r1 got=%0d exp=14", r1); end
    total++; if (r2 !== 32'd9) begin bad++; $display("FAIL b2b_r2 got=%0d exp=9", r2); end
    @(negedge clk_i);
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res;
    int seen = 0;
    @(negedge clk_i);
    a_i = 32'd100; b_i = 32'd7; is_q_i = 1'b1; req_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    req_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (ready_o) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_pulse got=%0d exp=0", seen); end
    total++; if (result_o !== 32'd9) begin bad++; $display("FAIL abort_hold got=%0d exp=9", result_o); end
    run_op(32'd20, 32'd3, 1'b1, lat, res);
    total++; if (lat !== 33) begin bad++; $display("FAIL post_abort_lat got=%0d exp=33", lat); end
    total++; if (res !== 32'd6) begin bad++; $display("FAIL post_abort got=%0d exp=6", res); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res;
    @(negedge clk_i);
    a_i = 32'd100; b_i = 32'd7; is_q_i = 1'b0; req_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b0; req_i = 1'b0;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ready_o); end
    total++; if (result_o !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h exp=0", result_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op(32'd20, 32'd3, 1'b0, lat, res);
    total++; if (lat !== 33) begin bad++; $display("FAIL postrst_lat got=%0d exp=33", lat); end
    total++; if (res !== 32'd2) begin bad++; $display("FAIL postrst_r got=%0d exp=2", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width_edges();
    test_div_zero();
    test_operand_hold();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
